// File: rtl/bit_serializer_pkg.sv
// Shared types and defaults for the bit_serializer stimulus stage.
// The PARITY state exists only when BIT_SERIALIZER_PARITY_EN is defined.
package bit_serializer_pkg;

    localparam int BIT_SERIALIZER_DEFAULT_WIDTH = 8;
    localparam int BIT_SERIALIZER_DEFAULT_GAP   = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
`ifdef BIT_SERIALIZER_PARITY_EN
        ST_PARITY = 2'd2,
`endif
        ST_GAP    = 2'd3
    } state_t;

endpackage

// File: rtl/bit_shift_reg.sv
// Loadable WIDTH-bit left-shift register with MSB tap; zero fills the vacated LSB.
module bit_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] load_value,
    output logic             msb
);

    logic [WIDTH-1:0] shift_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q <= '0;
        end else if (load) begin
            shift_q <= load_value;
        end else if (shift) begin
            shift_q <= {shift_q[WIDTH-2:0], 1'b0};
        end
    end

    assign msb = shift_q[WIDTH-1];

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial feeder for the ones detectors: MSB first, then GAP forced-zero cycles.
// Optional even-parity bit after each word when BIT_SERIALIZER_PARITY_EN is defined.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH = BIT_SERIALIZER_DEFAULT_WIDTH,
    parameter int GAP   = BIT_SERIALIZER_DEFAULT_GAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             data_out,
    output logic             data_valid,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W    = $clog2(WIDTH + 1);
    localparam int GAP_W    = (GAP < 2) ? 1 : $clog2(GAP + 1);
    localparam int GAP_LAST = (GAP > 0) ? GAP - 1 : 0;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] bit_cnt_q;
    logic [GAP_W-1:0] gap_cnt_q;
    logic             load_ready_q;
    logic             accept;
    logic             last_bit;
    logic             shift_msb;

    assign accept   = (state_q == ST_IDLE) && load_valid && load_ready_q;
    assign last_bit = (bit_cnt_q == CNT_W'(WIDTH - 1));

    bit_shift_reg #(
        .WIDTH(WIDTH)
    ) u_shift_reg (
        .clk        (clk),
        .reset      (reset),
        .load       (accept),
        .shift      (state_q == ST_SHIFT),
        .load_value (load_data),
        .msb        (shift_msb)
    );

`ifdef BIT_SERIALIZER_PARITY_EN
    logic parity_q;

    // Parity is taken from the captured word so later load_data changes cannot leak in.
    always_ff @(posedge clk) begin
        if (reset) begin
            parity_q <= 1'b0;
        end else if (accept) begin
            parity_q <= ^load_data;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (last_bit) begin
`ifdef BIT_SERIALIZER_PARITY_EN
                    state_d = ST_PARITY;
`else
                    state_d = (GAP > 0) ? ST_GAP : ST_IDLE;
`endif
                end
            end
`ifdef BIT_SERIALIZER_PARITY_EN
            ST_PARITY: begin
                state_d = (GAP > 0) ? ST_GAP : ST_IDLE;
            end
`endif
            ST_GAP: begin
                if (gap_cnt_q == GAP_W'(GAP_LAST)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // load_ready tracks the edge that enters IDLE, so it is low on the accepting edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            load_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            load_ready_q <= (state_d == ST_IDLE);
            if (accept) begin
                bit_cnt_q <= '0;
            end else if (state_q == ST_SHIFT) begin
                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
            if (state_q == ST_GAP) begin
                gap_cnt_q <= gap_cnt_q + GAP_W'(1);
            end else begin
                gap_cnt_q <= '0;
            end
        end
    end

    always_comb begin
        data_out   = 1'b0;
        data_valid = 1'b0;
        done       = 1'b0;
        case (state_q)
            ST_SHIFT: begin
                data_out   = shift_msb;
                data_valid = 1'b1;
`ifndef BIT_SERIALIZER_PARITY_EN
                done       = last_bit;
`endif
            end
`ifdef BIT_SERIALIZER_PARITY_EN
            ST_PARITY: begin
                data_out   = parity_q;
                data_valid = 1'b1;
                done       = 1'b1;
            end
`endif
            default: begin
            end
        endcase
    end

    assign busy       = (state_q != ST_IDLE);
    assign load_ready = load_ready_q;

endmodule

// File: doc/bit_serializer.md
# bit_serializer

Parallel-to-serial stimulus stage that feeds the serial `data_in` input of the ones-detector FSMs (Moore and Mealy variants). It accepts a WIDTH-bit word through a valid/ready handshake and shifts it out MSB first, one bit per clock. Idle zero bits are inserted between words so that consecutive words cannot merge into a false run of ones at the detector. An optional parity bit is compiled in with a macro.

## Interface
- `WIDTH`, default 8: word length in bits; minimum 2.
- `GAP`, default 2: number of forced-zero idle cycles after each word; 0 is allowed.
- `clk`  in  1: rising-edge clock.
- `reset`  in  1: synchronous, active-high reset.
- `load_valid`  in  1: the word on `load_data` is offered.
- `load_data`  in  WIDTH: word to serialize.
- `load_ready`  out  1: the block can accept a word; registered.
- `data_out`  out  1: serial bit; drives the detector's `data_in`.
- `data_valid`  out  1: `data_out` carries a word or parity bit.
- `busy`  out  1: a word is in flight, gap cycles included.
- `done`  out  1: one-cycle pulse on the last serial bit of a word.

## Operation
- FSM states: IDLE, SHIFT, PARITY, GAP. PARITY exists only with the macro defined.
- **IDLE**
  - `load_ready`=1.
  - Transfer when `load_valid && load_ready` at a rising edge: capture `load_data` into the shift register, clear the bit counter, go to SHIFT.
  - `load_valid` with `load_ready`=0 is ignored. No queueing.
- **SHIFT**
  - `data_out` = shift-register MSB, `data_valid`=1.
  - Register shifts left each cycle; zero fills the vacated LSB.
  - Bit counter width is $clog2(WIDTH+1).
  - After WIDTH cycles: go to PARITY if enabled. Otherwise go to GAP if GAP>0, else IDLE.
- **PARITY**
  - One cycle, `data_valid`=1, `data_out` = even parity (XOR of the word).
  - Then go to GAP if GAP>0, else IDLE.
- **GAP**
  - GAP cycles with `data_out`=0 and `data_valid`=0, then IDLE.
- Outside SHIFT and PARITY, `data_out` is forced to 0. The detector must never see stale ones.
- `busy` = state != IDLE.
- `done`=1 during the final SHIFT cycle, or during the PARITY cycle when parity is enabled.
- `load_ready` is set on the edge that enters IDLE. It is cleared on the accepting edge.

## Timing
- Reset values: `load_ready`=0, `data_out`=0, `data_valid`=0, `busy`=0, `done`=0. FSM goes to IDLE.
- `load_ready` rises on the first edge after `reset` deasserts.
- Latency: accept at edge k; the MSB appears on `data_out` in the cycle after edge k.
- Throughput: one word per 1 + WIDTH + P + GAP cycles (P=1 with parity, else 0). The 1 is the IDLE accept cycle.
- Reset mid-word: at the next edge the word is discarded, all outputs take their reset values, and no `done` pulse is produced.
- `reset` and `load_valid` asserted together: reset wins and nothing is captured.
- Changes on `load_data` after acceptance have no effect.

## Configuration
- Macro: `BIT_SERIALIZER_PARITY_EN`.
- Defined: PARITY state present. One even-parity bit follows each word; `done` marks the parity cycle.
- Undefined: no PARITY state; `done` marks the last data bit. The RTL carries no parity logic.

## Structure
- Package `bit_serializer_pkg` holds:
  - the state enum typedef (IDLE, SHIFT, PARITY, GAP);
  - `BIT_SERIALIZER_DEFAULT_WIDTH` and `BIT_SERIALIZER_DEFAULT_GAP`.
- One sub-module: `bit_shift_reg`, a WIDTH-bit loadable left-shift register with MSB tap. The FSM, counters and parity live in the top.

## Test plan
All scenarios use WIDTH=8, GAP=2 and MSB-first order. Edge numbers are counted from the accepting edge (edge 0).
- **Reset release:** hold `reset` 2 cycles, then release.
  - All outputs are 0 during reset.
  - `load_ready`=1 one edge after release.
- **Word 8'hE0, no parity:**
  - `data_out` = 1,1,1,0,0,0,0,0 in cycles 1–8, with `data_valid`=1.
  - `done` in cycle 8.
  - Cycles 9–10: `data_out`=0, `data_valid`=0.
  - `load_ready`=1 in cycle 11.
  - The detectors assert exactly once.
- **Word 8'hDB with `BIT_SERIALIZER_PARITY_EN`:**
  - Bits 1,1,0,1,1,0,1,1 in cycles 1–8.
  - Parity bit 0 in cycle 9, with `done` in cycle 9.
  - `load_ready` in cycle 12.
- **Back-to-back 8'hFF, 8'hFF with `load_valid` held:**
  - Accepts at edges 0 and 11.
  - Two zero cycles separate the runs of ones.
  - `load_valid` is ignored while `busy`=1.
- **Reset mid-word:** load 8'hAA and assert `reset` in cycle 4.
  - Next cycle: `data_out`=0, `data_valid`=0, no `done`.
  - Then a fresh 8'hAA serializes correctly.
- **GAP=0, word 8'h01:**
  - `done` in cycle 8.
  - IDLE with `load_ready`=1 in cycle 9.
